apb4_master: RTL and testbench
==============================

Name: apb4_master

Overview:
APB4 initiator (bridge) that converts a simple valid/ready command/response interface into APB4 SETUP/ACCESS transfers. It drives any APB4 completer on the peripheral bus, such as the GPIO, timer and UART blocks. It is used by test masters, DMA, and CPU-side bus bridges to reach APB peripherals. One outstanding transfer at a time, with wait-state support, PSLVERR reporting and an optional hang timeout.

Parameters:
PADDR_SIZE, 16, APB address width (bits)
PDATA_SIZE, 32, APB data width; multiple of 8
TIMEOUT, 255, max ACCESS-phase wait cycles with PREADY=0 before abort; 0 disables the timeout

Ports:
PRESETn  input  1  asynchronous active-low reset
PCLK  input  1  clock, rising edge
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid&cmd_ready
cmd_addr  input  PADDR_SIZE  transfer address
cmd_write  input  1  1=write, 0=read
cmd_wdata  input  PDATA_SIZE  write data
cmd_strb  input  PDATA_SIZE/8  write byte strobes
cmd_prot  input  3  PPROT value
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid&rsp_ready
rsp_rdata  output  PDATA_SIZE  read data; 0 for writes
rsp_err  output  1  PSLVERR seen, or timeout
rsp_timeout  output  1  transfer aborted by timeout
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PADDR  output  PADDR_SIZE  APB address
PWRITE  output  1  APB direction
PSTRB  output  PDATA_SIZE/8  APB strobes
PWDATA  output  PDATA_SIZE  APB write data
PPROT  output  3  APB protection
PRDATA  input  PDATA_SIZE  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB error

Behaviour:
- Reset is PRESETn, asynchronous, active-low; clock is PCLK.
- Reset values are 0 for all outputs: PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA, PPROT, rsp_valid, rsp_rdata, rsp_err and rsp_timeout. The FSM resets to IDLE.
- All APB outputs and all rsp_* outputs are registered. cmd_ready is a decode of the state (1 only in IDLE).
- FSM states are IDLE, SETUP, ACCESS and RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch the command onto PADDR, PWRITE, PWDATA and PPROT, set PSEL=1 and go to SETUP. PSTRB=cmd_strb for writes; PSTRB=0 for reads (forced).
- SETUP (PSEL=1, PENABLE=0): lasts exactly 1 cycle, then PENABLE<=1 and go to ACCESS.
- ACCESS (PSEL=1, PENABLE=1): PREADY, PRDATA and PSLVERR are sampled only here.
  - PREADY=1: rsp_rdata<=PWRITE?0:PRDATA; rsp_err<=PSLVERR; rsp_timeout<=0; PSEL<=0; PENABLE<=0; rsp_valid<=1; go to RESP.
  - PREADY=0: increment the wait counter (width clog2(TIMEOUT+1), cleared on entry to SETUP).
  - Timeout: TIMEOUT!=0, counter==TIMEOUT and PREADY=0. Abort with PSEL<=0, PENABLE<=0, rsp_err<=1, rsp_timeout<=1, rsp_rdata<=0; go to RESP.
- RESP: rsp_valid=1 with stable data. On rsp_ready, rsp_valid<=0 and go to IDLE.
- Latency: command accepted at edge T; PSEL=1 after T; PENABLE=1 after T+1. With zero wait states rsp_valid=1 after T+2, and the earliest next acceptance is the cycle after the rsp handshake. Throughput is at most 1 transfer per 4 cycles.
- PADDR, PWRITE, PWDATA, PSTRB and PPROT stay stable from SETUP through the end of ACCESS, and hold their last values while idle. They change only on command acceptance.
- PSLVERR is ignored when PREADY=0. PRDATA is ignored for writes.
- PREADY sampled high in the same cycle the counter reaches TIMEOUT: a normal completion wins, not a timeout.
- Asserting PRESETn mid-transfer drops PSEL and PENABLE immediately (async) and discards any pending response.
- cmd_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.

Test Plan:
- Zero-wait write: cmd addr=0x0008, wdata=0xA5A5_5A5A, strb=0xF; PREADY=1 -> PSEL high 2 cycles, PENABLE high on 2nd, PSTRB=0xF, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x0003, PREADY low 3 ACCESS cycles, PRDATA=0x0000_00C3 on ready -> PSTRB=0, PENABLE high 4 cycles, rsp_rdata=0xC3, address stable throughout.
- Error: write with PSLVERR=1 only while PREADY=1 -> rsp_err=1, rsp_timeout=0. Also PSLVERR=1 during wait cycles, then 0 at ready -> rsp_err=0.
- Timeout with TIMEOUT=4 and PREADY stuck 0 -> abort after 4 waiting ACCESS cycles, PSEL=0, rsp_err=1, rsp_timeout=1. Second run with PREADY=1 at count 4 -> normal completion.
- Backpressure: rsp_ready held 0 for 5 cycles with cmd_valid held high -> cmd_ready=0, no new PSEL, rsp_* stable; release -> next command accepted the cycle after the handshake.
- Reset mid-ACCESS: assert PRESETn low while PENABLE=1 -> PSEL, PENABLE and rsp_valid go 0 asynchronously; after release cmd_ready=1.

Source files
------------

// File: rtl/apb4_master.sv
// ============================================================================
// apb4_master : valid/ready command/response to APB4 SETUP/ACCESS initiator
// Revision    : 1.0
// ============================================================================
`default_nettype none

module apb4_master #(
  parameter int PADDR_SIZE = 16,
  parameter int PDATA_SIZE = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    PRESETn,
  input  logic                    PCLK,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [PADDR_SIZE-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [PDATA_SIZE-1:0]   cmd_wdata,
  input  logic [PDATA_SIZE/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [2:0]              PPROT,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int C_STRB_W = PDATA_SIZE / 8;
  // A disabled timeout still needs a legal (1-bit) counter.
  localparam int C_CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [C_CNT_W-1:0]    r_wait_cnt, w_wait_cnt_nxt;
  logic                  w_psel, w_penable, w_pwrite;
  logic [PADDR_SIZE-1:0] w_paddr;
  logic [C_STRB_W-1:0]   w_pstrb;
  logic [PDATA_SIZE-1:0] w_pwdata, w_rsp_rdata;
  logic [2:0]            w_pprot;
  logic                  w_rsp_valid, w_rsp_err, w_rsp_timeout;
  logic                  w_timeout;

  assign cmd_ready = (r_state == IDLE);
  // Completion has priority: only a cycle with PREADY low can time out.
  assign w_timeout = (TIMEOUT != 0) && (r_wait_cnt == C_CNT_W'(TIMEOUT)) && !PREADY;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_psel         = PSEL;
    w_penable      = PENABLE;
    w_paddr        = PADDR;
    w_pwrite       = PWRITE;
    w_pstrb        = PSTRB;
    w_pwdata       = PWDATA;
    w_pprot        = PPROT;
    w_rsp_valid    = rsp_valid;
    w_rsp_rdata    = rsp_rdata;
    w_rsp_err      = rsp_err;
    w_rsp_timeout  = rsp_timeout;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_paddr        = cmd_addr;
          w_pwrite       = cmd_write;
          w_pwdata       = cmd_wdata;
          w_pstrb        = cmd_write ? cmd_strb : '0;
          w_pprot        = cmd_prot;
          w_psel         = 1'b1;
          w_wait_cnt_nxt = '0;
          w_state_nxt    = SETUP;
        end
      end
      SETUP: begin
        w_penable   = 1'b1;
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          w_rsp_rdata   = PWRITE ? '0 : PRDATA;
          w_rsp_err     = PSLVERR;
          w_rsp_timeout = 1'b0;
          w_rsp_valid   = 1'b1;
          w_psel        = 1'b0;
          w_penable     = 1'b0;
          w_state_nxt   = RESP;
        end else if (w_timeout) begin
          w_rsp_rdata   = '0;
          w_rsp_err     = 1'b1;
          w_rsp_timeout = 1'b1;
          w_rsp_valid   = 1'b1;
          w_psel        = 1'b0;
          w_penable     = 1'b0;
          w_state_nxt   = RESP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PSTRB       <= '0;
      PWDATA      <= '0;
      PPROT       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      PSEL        <= w_psel;
      PENABLE     <= w_penable;
      PADDR       <= w_paddr;
      PWRITE      <= w_pwrite;
      PSTRB       <= w_pstrb;
      PWDATA      <= w_pwdata;
      PPROT       <= w_pprot;
      rsp_valid   <= w_rsp_valid;
      rsp_rdata   <= w_rsp_rdata;
      rsp_err     <= w_rsp_err;
      rsp_timeout <= w_rsp_timeout;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb4_master.sv
// ============================================================================
// tb_apb4_master : scoreboard bench for apb4_master (TIMEOUT = 4)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_apb4_master;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PWDATA, PRDATA;
  logic [2:0]    PPROT;

  apb4_master #(.PADDR_SIZE(AW), .PDATA_SIZE(DW), .TIMEOUT(TMO)) dut (
    .PRESETn(PRESETn), .PCLK(PCLK),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PSTRB(PSTRB), .PWDATA(PWDATA), .PPROT(PPROT), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic step();
    @(negedge PCLK);
  endtask

  // Presents a command at a negedge in IDLE; returns at the SETUP negedge.
  task automatic issue(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic [2:0] p);
    cmd_addr = a; cmd_write = w; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  // From the SETUP negedge: 'waits' ACCESS cycles with PREADY low, then ready.
  task automatic access(input int waits, input logic [DW-1:0] rd,
                        input logic err_rdy, input logic err_wait);
    PREADY = 1'b0; PSLVERR = err_wait; PRDATA = ~rd;
    step();
    repeat (waits) step();
    PREADY = 1'b1; PSLVERR = err_rdy; PRDATA = rd;
    step();
    PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  task automatic collect(output bit ok, output rsp_t got);
    ok = 1'b0;
    got = '0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) begin
      got.rdata = rsp_rdata; got.err = rsp_err; got.tmo = rsp_timeout;
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (3) step();
    n_vec++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout});
    end
    n_vec++;
    if ({PADDR, PSTRB, PWDATA, PPROT, rsp_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h required 0", {PADDR, PSTRB, PWDATA, PPROT, rsp_rdata});
    end
    PRESETn = 1'b1;
    step();
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_zero_wait_write();
    bit   ok;
    rsp_t got, exp;
    PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF;
    sb_q.push_back('{rdata: '0, err: 1'b0, tmo: 1'b0});
    issue(16'h0008, 1'b1, 32'hA5A5_5A5A, 4'hF, 3'b010);
    n_vec++;
    if ({PSEL, PENABLE, cmd_ready, PWRITE, PSTRB, PADDR, PWDATA, PPROT} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 16'h0008, 32'hA5A5_5A5A, 3'b010}) begin
      n_err++;
      $display("FAIL zw_setup: got %b_%b_%b_%b_%h_%h_%h_%h required 1_0_0_1_f_0008_a5a55a5a_2",
               PSEL, PENABLE, cmd_ready, PWRITE, PSTRB, PADDR, PWDATA, PPROT);
    end
    step();
    n_vec++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL zw_access: got %b required 110", {PSEL, PENABLE, rsp_valid});
    end
    step();
    n_vec++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b001) begin
      n_err++;
      $display("FAIL zw_resp: got %b required 001", {PSEL, PENABLE, rsp_valid});
    end
    PREADY = 1'b0;
    collect(ok, got);
    exp = sb_q.pop_front();
    n_vec++;
    if (!ok || got !== exp) begin
      n_err++;
      $display("FAIL zw_rsp: got ok=%0d %h required %h", ok, got, exp);
    end
    n_vec++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL zw_idle: got %b required 10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_read_wait();
    bit   ok, bad;
    rsp_t got, exp;
    PREADY = 1'b0; PRDATA = 32'h5555_5555;
    sb_q.push_back('{rdata: 32'h0000_00C3, err: 1'b0, tmo: 1'b0});
    issue(16'h0003, 1'b0, 32'h1111_2222, 4'hF, 3'b001);
    n_vec++;
    if ({PSEL, PENABLE, PWRITE, PSTRB} !== {3'b100, 4'h0}) begin
      n_err++;
      $display("FAIL rd_setup: got %b_%h required 100_0", {PSEL, PENABLE, PWRITE}, PSTRB);
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 16'h0003 || rsp_valid !== 1'b0)
        bad = 1'b1;
      if (i == 3) begin
        PREADY = 1'b1; PRDATA = 32'h0000_00C3;
      end
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL rd_access_hold: got unstable/short ACCESS required 4 cycles at 0003");
    end
    step();
    PREADY = 1'b0;
    n_vec++;
    if ({PENABLE, rsp_valid, PADDR} !== {2'b01, 16'h0003}) begin
      n_err++;
      $display("FAIL rd_end: got %b_%h required 01_0003", {PENABLE, rsp_valid}, PADDR);
    end
    collect(ok, got);
    exp = sb_q.pop_front();
    n_vec++;
    if (!ok || got !== exp) begin
      n_err++;
      $display("FAIL rd_rsp: got ok=%0d %h required %h", ok, got, exp);
    end
  endtask

  task automatic test_error();
    bit   ok;
    rsp_t got, exp;
    sb_q.push_back('{rdata: '0, err: 1'b1, tmo: 1'b0});
    issue(16'h0010, 1'b1, 32'hCAFE_F00D, 4'h3, 3'b000);
    access(0, 32'h9999_9999, 1'b1, 1'b0);
    collect(ok, got);
    exp = sb_q.pop_front();
    n_vec++;
    if (!ok || got !== exp) begin
      n_err++;
      $display("FAIL err_at_ready: got ok=%0d %h required %h", ok, got, exp);
    end
    sb_q.push_back('{rdata: 32'h0000_1234, err: 1'b0, tmo: 1'b0});
    issue(16'h0014, 1'b0, 32'h0, 4'h0, 3'b000);
    access(2, 32'h0000_1234, 1'b0, 1'b1);
    collect(ok, got);
    exp = sb_q.pop_front();
    n_vec++;
    if (!ok || got !== exp) begin
      n_err++;
      $display("FAIL err_during_wait: got ok=%0d %h required %h", ok, got, exp);
    end
  endtask

  task automatic test_timeout();
    bit   ok;
    int   cnt;
    rsp_t got, exp;
    PREADY = 1'b0; PRDATA = 32'hFFFF_0000;
    sb_q.push_back('{rdata: '0, err: 1'b1, tmo: 1'b1});
    issue(16'h0040, 1'b0, 32'h0, 4'h0, 3'b000);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rsp_valid) break;
      if (PENABLE) cnt++;
    end
    n_vec++;
    if (cnt != TMO + 1 || PSEL !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_cycles: got %0d ACCESS cycles psel=%b required %0d psel=0", cnt, PSEL, TMO + 1);
    end
    collect(ok, got);
    exp = sb_q.pop_front();
    n_vec++;
    if (!ok || got !== exp) begin
      n_err++;
      $display("FAIL tmo_rsp: got ok=%0d %h required %h", ok, got, exp);
    end
    sb_q.push_back('{rdata: 32'h0BAD_CAFE, err: 1'b0, tmo: 1'b0});
    issue(16'h0044, 1'b0, 32'h0, 4'h0, 3'b000);
    access(TMO, 32'h0BAD_CAFE, 1'b0, 1'b0);
    collect(ok, got);
    exp = sb_q.pop_front();
    n_vec++;
    if (!ok || got !== exp) begin
      n_err++;
      $display("FAIL tmo_ready_wins: got ok=%0d %h required %h", ok, got, exp);
    end
  endtask

  task automatic test_backpressure();
    bit   ok, bad;
    rsp_t got, exp, snap;
    sb_q.push_back('{rdata: '0, err: 1'b0, tmo: 1'b0});
    issue(16'h0100, 1'b1, 32'h0102_0304, 4'hC, 3'b100);
    access(0, 32'h7777_7777, 1'b0, 1'b0);
    cmd_addr = 16'h0200; cmd_write = 1'b0; cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    snap = '{rdata: rsp_rdata, err: rsp_err, tmo: rsp_timeout};
    bad = 1'b0;
    repeat (5) begin
      step();
      if (cmd_ready !== 1'b0 || PSEL !== 1'b0 || rsp_valid !== 1'b1 ||
          {rsp_rdata, rsp_err, rsp_timeout} !== snap)
        bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL bp_hold: got response/bus activity while stalled required stable RESP");
    end
    exp = sb_q.pop_front();
    n_vec++;
    if (snap !== exp) begin
      n_err++;
      $display("FAIL bp_rsp: got %h required %h", snap, exp);
    end
    sb_q.push_back('{rdata: 32'h2020_2020, err: 1'b0, tmo: 1'b0});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_vec++;
    if ({rsp_valid, cmd_ready, PSEL} !== 3'b010) begin
      n_err++;
      $display("FAIL bp_release: got %b required 010", {rsp_valid, cmd_ready, PSEL});
    end
    step();
    cmd_valid = 1'b0;
    n_vec++;
    if ({PSEL, PADDR} !== {1'b1, 16'h0200}) begin
      n_err++;
      $display("FAIL bp_next_accept: got %b_%h required 1_0200", PSEL, PADDR);
    end
    access(1, 32'h2020_2020, 1'b0, 1'b0);
    collect(ok, got);
    exp = sb_q.pop_front();
    n_vec++;
    if (!ok || got !== exp) begin
      n_err++;
      $display("FAIL bp_next_rsp: got ok=%0d %h required %h", ok, got, exp);
    end
  endtask

  task automatic test_back_to_back();
    bit            ok, w, e;
    int            waits;
    logic [DW-1:0] rd;
    rsp_t          got, exp;
    for (int k = 0; k < 6; k++) begin
      w = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 3);
      rd = $urandom;
      sb_q.push_back('{rdata: w ? '0 : rd, err: e, tmo: 1'b0});
      issue(16'($urandom), w, $urandom, 4'($urandom), 3'($urandom));
      access(waits, rd, e, 1'b1);
      collect(ok, got);
      exp = sb_q.pop_front();
      n_vec++;
      if (!ok || got !== exp) begin
        n_err++;
        $display("FAIL b2b_%0d: got ok=%0d %h required %h", k, ok, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    rsp_t got, exp;
    PREADY = 1'b0;
    issue(16'h0ABC, 1'b1, 32'h1357_9BDF, 4'hF, 3'b000);
    step();
    n_vec++;
    if (PENABLE !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: got penable=%b required 1", PENABLE);
    end
    #2 PRESETn = 1'b0;
    #1;
    n_vec++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL rstmid_async: got %b required 0001", {PSEL, PENABLE, rsp_valid, cmd_ready});
    end
    step();
    PRESETn = 1'b1;
    step();
    n_vec++;
    if ({cmd_ready, rsp_valid, PSEL} !== 3'b100) begin
      n_err++;
      $display("FAIL rstmid_after: got %b required 100", {cmd_ready, rsp_valid, PSEL});
    end
    sb_q.push_back('{rdata: 32'h00C0_FFEE, err: 1'b0, tmo: 1'b0});
    issue(16'h0AC0, 1'b0, 32'h0, 4'h0, 3'b000);
    access(1, 32'h00C0_FFEE, 1'b0, 1'b0);
    collect(ok, got);
    exp = sb_q.pop_front();
    n_vec++;
    if (!ok || got !== exp) begin
      n_err++;
      $display("FAIL rstmid_recover: got ok=%0d %h required %h", ok, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish");
    $fatal(1);
  end

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    test_reset();
    test_zero_wait_write();
    test_read_wait();
    test_error();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
